// File: rtl/branch_predictor_if.sv
// Fetch/execute signal bundle between the pipeline and the branch predictor.
// The pipeline side is the master and the predictor side is the slave.
interface branch_predictor_if;
  logic [31:0] PCF;
  logic        Predict_branchF;
  logic [31:0] PredTargetF;
  logic        BranchE;
  logic        JumpE;
  logic        TakenE;
  logic        Predict_branchE;
  logic [31:0] PCE;
  logic [31:0] PCTargetE;
  logic [31:0] PCPlus4E;
  logic        MispredictE;
  logic [31:0] PCCorrectE;

  modport master (
    output PCF, BranchE, JumpE, TakenE, Predict_branchE, PCE, PCTargetE, PCPlus4E,
    input  Predict_branchF, PredTargetF, MispredictE, PCCorrectE
  );

  modport slave (
    input  PCF, BranchE, JumpE, TakenE, Predict_branchE, PCE, PCTargetE, PCPlus4E,
    output Predict_branchF, PredTargetF, MispredictE, PCCorrectE
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB predictor with 2-bit counters: combinational lookup on PCF,
// table update and mispredict redirect from the execute stage. BP_STATS_EN adds counters.
module branch_predictor #(
  parameter int INDEX_BITS = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_predictor_if.slave bp
`ifdef BP_STATS_EN
  ,
  output logic [31:0]       BranchCount,
  output logic [31:0]       MispredictCount
`endif
);
  localparam int TAG_BITS = 30 - INDEX_BITS;
  localparam int ENTRIES  = 1 << INDEX_BITS;

  logic                entryValid  [ENTRIES];
  logic [TAG_BITS-1:0] entryTag    [ENTRIES];
  logic [31:0]         entryTarget [ENTRIES];
  logic [1:0]          entryCtr    [ENTRIES];

  logic [INDEX_BITS-1:0] idxF, idxE;
  logic [TAG_BITS-1:0]   tagF, tagE;
  logic                  hitF, hitE;

  assign idxF = bp.PCF[INDEX_BITS+1:2];
  assign tagF = bp.PCF[31:INDEX_BITS+2];
  assign idxE = bp.PCE[INDEX_BITS+1:2];
  assign tagE = bp.PCE[31:INDEX_BITS+2];
  assign hitF = entryValid[idxF] && (entryTag[idxF] == tagF);
  assign hitE = entryValid[idxE] && (entryTag[idxE] == tagE);

  assign bp.Predict_branchF = hitF && entryCtr[idxF][1];
  assign bp.PredTargetF     = hitF ? entryTarget[idxF] : 32'd0;

  logic        mispredict;
  logic [31:0] pcCorrect;

  // A conditional branch wins over JumpE when both are flagged.
  always_comb begin
    mispredict = 1'b0;
    pcCorrect  = 32'd0;
    if (bp.BranchE) begin
      if (bp.TakenE && !bp.Predict_branchE) begin
        mispredict = 1'b1;
        pcCorrect  = bp.PCTargetE;
      end else if (!bp.TakenE && bp.Predict_branchE) begin
        mispredict = 1'b1;
        pcCorrect  = bp.PCPlus4E;
      end
    end else if (!bp.JumpE && bp.Predict_branchE) begin
      mispredict = 1'b1;
      pcCorrect  = bp.PCPlus4E;
    end
  end

  assign bp.MispredictE = mispredict;
  assign bp.PCCorrectE  = pcCorrect;

  logic        wrEn;
  logic        wrValid;
  logic [31:0] wrTarget;
  logic [1:0]  wrCtr;

  always_comb begin
    wrEn     = 1'b0;
    wrValid  = entryValid[idxE];
    wrTarget = entryTarget[idxE];
    wrCtr    = entryCtr[idxE];
    if (bp.BranchE) begin
      if (hitE) begin
        wrEn = 1'b1;
        if (bp.TakenE) begin
          wrCtr    = (entryCtr[idxE] == 2'b11) ? 2'b11 : entryCtr[idxE] + 2'd1;
          wrTarget = bp.PCTargetE;
        end else begin
          wrCtr = (entryCtr[idxE] == 2'b00) ? 2'b00 : entryCtr[idxE] - 2'd1;
        end
      end else if (bp.TakenE) begin
        wrEn     = 1'b1;
        wrValid  = 1'b1;
        wrTarget = bp.PCTargetE;
        wrCtr    = 2'b10;
      end
    end else if (bp.Predict_branchE && hitE) begin
      // Entry produced a taken prediction for a non-branch: it is stale or aliased.
      wrEn    = 1'b1;
      wrValid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entryValid[i]  <= 1'b0;
        entryTag[i]    <= '0;
        entryTarget[i] <= 32'd0;
        entryCtr[i]    <= 2'b01;
      end
    end else if (wrEn) begin
      entryValid[idxE]  <= wrValid;
      entryTag[idxE]    <= tagE;
      entryTarget[idxE] <= wrTarget;
      entryCtr[idxE]    <= wrCtr;
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      BranchCount     <= 32'd0;
      MispredictCount <= 32'd0;
    end else begin
      if (bp.BranchE) BranchCount <= BranchCount + 32'd1;
      if (mispredict) MispredictCount <= MispredictCount + 32'd1;
    end
  end
`endif
endmodule
